// File: rtl/regfile_arbiter_if.sv
// rtl/regfile_arbiter_if.sv - requester and register-file bus shared by the arbiter and its environment
interface regfile_arbiter_if #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 32,
  parameter int AW    = 5
);
  logic             a_req, b_req;
  logic             a_we, b_we;
  logic [AW-1:0]    a_ra, a_rb, a_wa;
  logic [AW-1:0]    b_ra, b_rb, b_wa;
  logic [WIDTH-1:0] a_wdata, b_wdata;
  logic             a_gnt, b_gnt;
  logic             a_done, b_done;
  logic [WIDTH-1:0] rdata, rdata2;
  logic [SIZE-1:0]  rf_selectR, rf_selectR2, rf_selectW;
  logic             rf_enable;
  logic [WIDTH-1:0] rf_in;
  logic [WIDTH-1:0] rf_out, rf_out2;
  logic             busy;

  modport slave (
    input  a_req, b_req, a_we, b_we, a_ra, a_rb, a_wa, b_ra, b_rb, b_wa,
    input  a_wdata, b_wdata, rf_out, rf_out2,
    output a_gnt, b_gnt, a_done, b_done, rdata, rdata2,
    output rf_selectR, rf_selectR2, rf_selectW, rf_enable, rf_in, busy
  );

  modport master (
    output a_req, b_req, a_we, b_we, a_ra, a_rb, a_wa, b_ra, b_rb, b_wa,
    output a_wdata, b_wdata, rf_out, rf_out2,
    input  a_gnt, b_gnt, a_done, b_done, rdata, rdata2,
    input  rf_selectR, rf_selectR2, rf_selectW, rf_enable, rf_in, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// rtl/regfile_arbiter.sv - two-requester round-robin arbiter in front of a 2-read/1-write register file
module regfile_arbiter #(
  parameter int WIDTH = 32,
  parameter int SIZE  = 32,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             reset,
  regfile_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t           state, state_next;
  logic             ptr, ptr_next;
  logic             owner, owner_next;
  logic             winner;
  logic             take;
  logic             lat_we;
  logic [AW-1:0]    lat_ra, lat_rb, lat_wa;
  logic [WIDTH-1:0] lat_wdata;
  logic [WIDTH-1:0] rdata_q, rdata2_q;

  function automatic logic [SIZE-1:0] one_hot(input logic [AW-1:0] idx);
    logic [SIZE-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // ptr: 0 = A wins a tie, 1 = B wins a tie
  always_comb begin
    winner = ptr;
    if (bus.a_req && !bus.b_req) winner = 1'b0;
    else if (!bus.a_req && bus.b_req) winner = 1'b1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      ptr   <= 1'b0;
      owner <= 1'b0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
      owner <= owner_next;
    end
  end

  always_comb begin
    state_next      = state;
    ptr_next        = ptr;
    owner_next      = owner;
    take            = 1'b0;
    bus.a_gnt       = 1'b0;
    bus.b_gnt       = 1'b0;
    bus.a_done      = 1'b0;
    bus.b_done      = 1'b0;
    bus.rf_selectR  = '0;
    bus.rf_selectR2 = '0;
    bus.rf_selectW  = '0;
    bus.rf_enable   = 1'b0;
    bus.rf_in       = '0;
    case (state)
      IDLE: begin
        if (bus.a_req || bus.b_req) begin
          take       = 1'b1;
          state_next = ACCESS;
          owner_next = winner;
          ptr_next   = !winner;
        end
      end
      ACCESS: begin
        state_next      = RESP;
        bus.a_gnt       = !owner;
        bus.b_gnt       = owner;
        bus.rf_selectR  = one_hot(lat_ra);
        bus.rf_selectR2 = one_hot(lat_rb);
        // r0 is hardwired zero, so writes to it are swallowed here
        if (lat_we && (lat_wa != '0)) begin
          bus.rf_selectW = one_hot(lat_wa);
          bus.rf_enable  = 1'b1;
          bus.rf_in      = lat_wdata;
        end
      end
      RESP: begin
        state_next = IDLE;
        bus.a_done = !owner;
        bus.b_done = owner;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      lat_we    <= 1'b0;
      lat_ra    <= '0;
      lat_rb    <= '0;
      lat_wa    <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      rdata2_q  <= '0;
    end else begin
      if (take) begin
        lat_we    <= winner ? bus.b_we    : bus.a_we;
        lat_ra    <= winner ? bus.b_ra    : bus.a_ra;
        lat_rb    <= winner ? bus.b_rb    : bus.a_rb;
        lat_wa    <= winner ? bus.b_wa    : bus.a_wa;
        lat_wdata <= winner ? bus.b_wdata : bus.a_wdata;
      end
      // read buses still show pre-write contents on this edge
      if (state == ACCESS) begin
        rdata_q  <= bus.rf_out;
        rdata2_q <= bus.rf_out2;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.rdata  = rdata_q;
  assign bus.rdata2 = rdata2_q;
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb/tb_regfile_arbiter.sv - scoreboard bench for regfile_arbiter with a behavioural register file
module tb_regfile_arbiter;
  localparam int WIDTH = 32;
  localparam int SIZE  = 32;
  localparam int AW    = 5;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  regfile_arbiter_if #(.WIDTH(WIDTH), .SIZE(SIZE), .AW(AW)) bus ();
  regfile_arbiter #(.WIDTH(WIDTH), .SIZE(SIZE), .AW(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

  int vectors     = 0;
  int miscompares = 0;

  logic             mem_init;
  logic [WIDTH-1:0] rf_mem [SIZE];
  logic [WIDTH-1:0] shadow [SIZE];

  typedef struct {
    logic [WIDTH-1:0] r1;
    logic [WIDTH-1:0] r2;
  } exp_t;
  exp_t exp_q[$];
  bit   own_q[$];

  typedef struct {
    bit               timeout;
    int               gnt_cyc;
    int               done_cyc;
    bit               other_gnt;
    bit               busy_acc;
    logic [WIDTH-1:0] rdata, rdata2, rf_in_acc;
    logic [SIZE-1:0]  sel_r_acc, sel_r2_acc, sel_w_acc, sel_r_idle, sel_w_any;
    logic             en_acc, en_any;
  } obs_t;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < SIZE; i++) rf_mem[i] <= '0;
    end else begin
      for (int i = 1; i < SIZE; i++)
        if (bus.rf_enable && bus.rf_selectW[i]) rf_mem[i] <= bus.rf_in;
    end
  end

  always_comb begin
    bus.rf_out  = '0;
    bus.rf_out2 = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (bus.rf_selectR[i])  bus.rf_out  = bus.rf_out  | rf_mem[i];
      if (bus.rf_selectR2[i]) bus.rf_out2 = bus.rf_out2 | rf_mem[i];
    end
  end

  task automatic set_req(input bit who, input bit req, input bit we, input logic [AW-1:0] ra,
                         input logic [AW-1:0] rb, input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd);
    if (!who) begin
      bus.a_req = req; bus.a_we = we; bus.a_ra = ra; bus.a_rb = rb; bus.a_wa = wa; bus.a_wdata = wd;
    end else begin
      bus.b_req = req; bus.b_we = we; bus.b_ra = ra; bus.b_rb = rb; bus.b_wa = wa; bus.b_wdata = wd;
    end
  endtask

  task automatic do_txn(input bit who, input bit we, input logic [AW-1:0] ra, input logic [AW-1:0] rb,
                        input logic [AW-1:0] wa, input logic [WIDTH-1:0] wd, output obs_t o);
    exp_t e;
    o.timeout = 1'b1; o.gnt_cyc = 0; o.done_cyc = 0; o.other_gnt = 1'b0; o.busy_acc = 1'b0;
    o.rdata = '0; o.rdata2 = '0; o.rf_in_acc = '0;
    o.sel_r_acc = '0; o.sel_r2_acc = '0; o.sel_w_acc = '0; o.sel_r_idle = '0; o.sel_w_any = '0;
    o.en_acc = 1'b0; o.en_any = 1'b0;
    e.r1 = shadow[ra];
    e.r2 = shadow[rb];
    exp_q.push_back(e);
    if (we && (wa != '0)) shadow[wa] = wd;
    @(negedge clk);
    o.sel_r_idle = bus.rf_selectR;
    set_req(who, 1'b1, we, ra, rb, wa, wd);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      o.en_any    = o.en_any | bus.rf_enable;
      o.sel_w_any = o.sel_w_any | bus.rf_selectW;
      if (who ? bus.a_gnt : bus.b_gnt) o.other_gnt = 1'b1;
      if (who ? bus.b_gnt : bus.a_gnt) begin
        o.gnt_cyc    = c;
        o.sel_r_acc  = bus.rf_selectR;
        o.sel_r2_acc = bus.rf_selectR2;
        o.sel_w_acc  = bus.rf_selectW;
        o.en_acc     = bus.rf_enable;
        o.rf_in_acc  = bus.rf_in;
        o.busy_acc   = bus.busy;
        // scramble the request fields to prove the arbiter latched them
        set_req(who, 1'b0, 1'($urandom), AW'($urandom), AW'($urandom), AW'($urandom), $urandom);
      end else begin
        o.sel_r_idle = o.sel_r_idle | bus.rf_selectR;
      end
      if (who ? bus.b_done : bus.a_done) begin
        o.done_cyc = c;
        o.rdata    = bus.rdata;
        o.rdata2   = bus.rdata2;
        o.timeout  = 1'b0;
        break;
      end
    end
    set_req(who, 1'b0, 1'b0, '0, '0, '0, '0);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", bus.busy); end
    vectors++; if ({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done} !== 4'b0) begin miscompares++; $display("FAIL rst_gnt_done: got %b want 0000", {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}); end
    vectors++; if ({bus.rdata, bus.rdata2} !== 64'h0) begin miscompares++; $display("FAIL rst_rdata: got %h want 0", {bus.rdata, bus.rdata2}); end
    vectors++; if ({bus.rf_selectR, bus.rf_selectR2, bus.rf_selectW} !== 96'h0) begin miscompares++; $display("FAIL rst_selects: got %h want 0", {bus.rf_selectR, bus.rf_selectR2, bus.rf_selectW}); end
    vectors++; if ({bus.rf_enable, bus.rf_in} !== 33'h0) begin miscompares++; $display("FAIL rst_rf_write: got %h want 0", {bus.rf_enable, bus.rf_in}); end
    mem_init = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL idle_busy: got %b want 0", bus.busy); end
  endtask

  task automatic test_write_read();
    obs_t o; exp_t e;
    do_txn(1'b0, 1'b1, 5'd0, 5'd0, 5'd5, 32'hDEADBEEF, o); e = exp_q.pop_front();
    vectors++; if (o.timeout !== 1'b0) begin miscompares++; $display("FAIL wr5_done: got timeout=%b want 0", o.timeout); end
    vectors++; if (o.en_acc !== 1'b1) begin miscompares++; $display("FAIL wr5_enable: got %b want 1", o.en_acc); end
    vectors++; if (o.sel_w_acc !== 32'h20) begin miscompares++; $display("FAIL wr5_selw: got %h want 00000020", o.sel_w_acc); end
    vectors++; if (o.rf_in_acc !== 32'hDEADBEEF) begin miscompares++; $display("FAIL wr5_rf_in: got %h want deadbeef", o.rf_in_acc); end
    vectors++; if (o.busy_acc !== 1'b1) begin miscompares++; $display("FAIL wr5_busy: got %b want 1", o.busy_acc); end
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL wr5_rdata: got %h want %h", o.rdata, e.r1); end
    do_txn(1'b0, 1'b0, 5'd5, 5'd0, 5'd0, '0, o); e = exp_q.pop_front();
    vectors++; if (o.gnt_cyc !== 1) begin miscompares++; $display("FAIL rd5_gnt_lat: got %0d want 1", o.gnt_cyc); end
    vectors++; if (o.done_cyc !== 2) begin miscompares++; $display("FAIL rd5_done_lat: got %0d want 2", o.done_cyc); end
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL rd5_rdata: got %h want %h", o.rdata, e.r1); end
    vectors++; if (o.rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd5_rdata_const: got %h want deadbeef", o.rdata); end
    vectors++; if (o.rdata2 !== e.r2) begin miscompares++; $display("FAIL rd5_rdata2: got %h want %h", o.rdata2, e.r2); end
    vectors++; if (o.other_gnt !== 1'b0) begin miscompares++; $display("FAIL rd5_other_gnt: got %b want 0", o.other_gnt); end
    vectors++; if ({o.en_any, o.sel_w_any} !== 33'h0) begin miscompares++; $display("FAIL rd5_no_write: got %h want 0", {o.en_any, o.sel_w_any}); end
  endtask

  task automatic test_r0_write();
    obs_t o; exp_t e;
    do_txn(1'b1, 1'b1, 5'd0, 5'd0, 5'd0, 32'h1234, o); e = exp_q.pop_front();
    vectors++; if (o.timeout !== 1'b0) begin miscompares++; $display("FAIL r0w_b_done: got timeout=%b want 0", o.timeout); end
    vectors++; if (o.en_any !== 1'b0) begin miscompares++; $display("FAIL r0w_enable: got %b want 0", o.en_any); end
    vectors++; if (o.sel_w_any !== '0) begin miscompares++; $display("FAIL r0w_selw: got %h want 0", o.sel_w_any); end
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL r0w_rdata: got %h want %h", o.rdata, e.r1); end
    do_txn(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, '0, o); e = exp_q.pop_front();
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL r0r_rdata: got %h want %h", o.rdata, e.r1); end
    vectors++; if (o.rdata !== 32'h0) begin miscompares++; $display("FAIL r0r_rdata_const: got %h want 0", o.rdata); end
  endtask

  task automatic test_read_before_write();
    obs_t o; exp_t e;
    do_txn(1'b0, 1'b1, 5'd0, 5'd0, 5'd7, 32'h11, o); e = exp_q.pop_front();
    vectors++; if (o.timeout !== 1'b0) begin miscompares++; $display("FAIL r7_init_done: got timeout=%b want 0", o.timeout); end
    do_txn(1'b0, 1'b1, 5'd7, 5'd7, 5'd7, 32'h22, o); e = exp_q.pop_front();
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL rbw_rdata: got %h want %h", o.rdata, e.r1); end
    vectors++; if (o.rdata !== 32'h11) begin miscompares++; $display("FAIL rbw_rdata_const: got %h want 00000011", o.rdata); end
    vectors++; if (o.rdata2 !== e.r2) begin miscompares++; $display("FAIL rbw_rdata2: got %h want %h", o.rdata2, e.r2); end
    do_txn(1'b1, 1'b0, 5'd7, 5'd5, 5'd0, '0, o); e = exp_q.pop_front();
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL r7_after_rdata: got %h want %h", o.rdata, e.r1); end
    vectors++; if (o.rdata !== 32'h22) begin miscompares++; $display("FAIL r7_after_const: got %h want 00000022", o.rdata); end
    vectors++; if (o.rdata2 !== e.r2) begin miscompares++; $display("FAIL r7_after_rdata2: got %h want %h", o.rdata2, e.r2); end
  endtask

  task automatic test_round_robin();
    int  last_g, ngnt, nchk;
    bit  pend, pend_who, w, want;
    apply_reset();
    own_q = {};
    own_q.push_back(1'b0); own_q.push_back(1'b1); own_q.push_back(1'b0); own_q.push_back(1'b1);
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 5'd5, 5'd7, 5'd0, '0);
    set_req(1'b1, 1'b1, 1'b0, 5'd7, 5'd5, 5'd0, '0);
    last_g = 0; ngnt = 0; nchk = 0; pend = 1'b0; pend_who = 1'b0;
    for (int c = 1; c <= 40 && nchk < 4; c++) begin
      @(negedge clk);
      if (pend) begin
        vectors++; if ((pend_who ? bus.b_done : bus.a_done) !== 1'b1) begin miscompares++; $display("FAIL rr_done: cycle %0d got done a=%b b=%b want owner %0d", c, bus.a_done, bus.b_done, pend_who); end
        pend = 1'b0;
        nchk++;
      end
      vectors++; if ((bus.a_gnt & bus.b_gnt) !== 1'b0) begin miscompares++; $display("FAIL rr_dual_gnt: got both grants at cycle %0d want one", c); end
      if (bus.a_gnt || bus.b_gnt) begin
        w = bus.b_gnt;
        vectors++;
        if (own_q.size() == 0) begin
          miscompares++; $display("FAIL rr_extra_gnt: got grant to %0d want none", w);
        end else begin
          want = own_q.pop_front();
          if (w !== want) begin miscompares++; $display("FAIL rr_owner: grant %0d got %0d want %0d", ngnt, w, want); end
        end
        vectors++; if (c !== ((ngnt == 0) ? 1 : last_g + 3)) begin miscompares++; $display("FAIL rr_spacing: grant %0d got cycle %0d want %0d", ngnt, c, (ngnt == 0) ? 1 : last_g + 3); end
        last_g = c; ngnt++; pend = 1'b1; pend_who = w;
      end
    end
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    vectors++; if (nchk !== 4) begin miscompares++; $display("FAIL rr_timeout: got %0d completions want 4", nchk); end
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    obs_t o; exp_t e;
    do_txn(1'b0, 1'b1, 5'd5, 5'd0, 5'd3, 32'h33, o); e = exp_q.pop_front();
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL r3_init_rdata: got %h want %h", o.rdata, e.r1); end
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b1, 5'd3, 5'd3, 5'd3, 32'h99);
    @(posedge clk);
    #2;
    vectors++; if (bus.a_gnt !== 1'b1) begin miscompares++; $display("FAIL abort_in_access: got gnt %b want 1", bus.a_gnt); end
    reset = 1'b0;
    #1;
    vectors++; if (bus.busy !== 1'b0) begin miscompares++; $display("FAIL abort_busy: got %b want 0", bus.busy); end
    vectors++; if ({bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done} !== 4'b0) begin miscompares++; $display("FAIL abort_gnt_done: got %b want 0000", {bus.a_gnt, bus.b_gnt, bus.a_done, bus.b_done}); end
    vectors++; if ({bus.rf_enable, bus.rf_selectW, bus.rf_in} !== 65'h0) begin miscompares++; $display("FAIL abort_rf_write: got %h want 0", {bus.rf_enable, bus.rf_selectW, bus.rf_in}); end
    vectors++; if ({bus.rf_selectR, bus.rf_selectR2} !== 64'h0) begin miscompares++; $display("FAIL abort_selr: got %h want 0", {bus.rf_selectR, bus.rf_selectR2}); end
    vectors++; if ({bus.rdata, bus.rdata2} !== 64'h0) begin miscompares++; $display("FAIL abort_rdata: got %h want 0", {bus.rdata, bus.rdata2}); end
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vectors++; if ((bus.a_done | bus.b_done) !== 1'b0) begin miscompares++; $display("FAIL abort_no_done: cycle %0d got done want 0", c); end
    end
    do_txn(1'b0, 1'b0, 5'd3, 5'd0, 5'd0, '0, o); e = exp_q.pop_front();
    vectors++; if (o.rdata !== e.r1) begin miscompares++; $display("FAIL abort_r3_kept: got %h want %h", o.rdata, e.r1); end
    vectors++; if (o.rdata !== 32'h33) begin miscompares++; $display("FAIL abort_r3_const: got %h want 00000033", o.rdata); end
  endtask

  task automatic test_select_scan();
    obs_t o; exp_t e;
    logic [SIZE-1:0] one;
    for (int i = 0; i < SIZE; i++) begin
      do_txn(i[0], 1'b0, AW'(i), AW'(SIZE - 1 - i), 5'd0, '0, o); e = exp_q.pop_front();
      one = '0; one[i] = 1'b1;
      vectors++; if (o.sel_r_acc !== one) begin miscompares++; $display("FAIL scan_selr ra=%0d: got %h want %h", i, o.sel_r_acc, one); end
      one = '0; one[SIZE - 1 - i] = 1'b1;
      vectors++; if (o.sel_r2_acc !== one) begin miscompares++; $display("FAIL scan_selr2 rb=%0d: got %h want %h", SIZE - 1 - i, o.sel_r2_acc, one); end
      vectors++; if (o.sel_r_idle !== '0) begin miscompares++; $display("FAIL scan_selr_idle ra=%0d: got %h want 0", i, o.sel_r_idle); end
      vectors++; if ({o.rdata, o.rdata2} !== {e.r1, e.r2}) begin miscompares++; $display("FAIL scan_rdata ra=%0d: got %h want %h", i, {o.rdata, o.rdata2}, {e.r1, e.r2}); end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got time limit want normal end");
    $fatal(1);
  end

  initial begin
    reset    = 1'b0;
    mem_init = 1'b1;
    for (int i = 0; i < SIZE; i++) shadow[i] = '0;
    set_req(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    set_req(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);
    test_reset();
    test_write_read();
    test_r0_write();
    test_read_before_write();
    test_round_robin();
    test_reset_abort();
    test_select_scan();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
